dff_exerciser: RTL and testbench
================================

Name: dff_exerciser

Overview:
Self-checking stimulus controller for a bank of W D flip-flops clocked from the same clk. It sequences the bank's set, clear and data inputs through STEPS pseudo-random vectors and samples Dout after LAT cycles. It compares each sample against a reference model, then reports pass/fail, a mismatch count and the first failing step. It is the bench-side/board-side sequencer for the flip-flop lab experiment, so the exercise needs no hand-toggled switches.

Parameters:
W, 1, flip-flop bank width (1..4).
STEPS, 8, vectors applied per run (1..255).
LAT, 1, cycles from vector drive to valid dout (1..4).
SEED, 8'hA5, LFSR start value; 8'h00 is replaced by 8'h01.

Ports:
clk  input  1  system clock; all state updates on rising edge.
clr  input  1  synchronous active-low reset.
start  input  1  one-cycle request to begin a run; sampled only in IDLE.
dout  input  W  Dout of the flip-flop bank under test.
dff_set  output  1  preset to bank, active-high (forces all bits to 1).
dff_clr  output  1  clear to bank, active-high (forces all bits to 0; wins over set).
dff_din  output  W  data to bank.
busy  output  1  high from the cycle after start until DONE is exited.
done  output  1  one-cycle pulse in the DONE state.
pass  output  1  err_cnt==0 at end of run; held until next accepted start.
err_cnt  output  8  mismatches in current/last run; saturates at 255.
fail_step  output  8  step index of first mismatch; 8'hFF if none.

Behaviour:
- Reset (clr=0 at an edge): state=IDLE; all outputs 0 except fail_step=8'hFF; LFSR=SEED; step=0. Takes effect mid-run too; the run is abandoned with no done pulse.
- All outputs are registered.
- LFSR: 8-bit Fibonacci, fb=l[7]^l[5]^l[4]^l[3], next={l[6:0],fb}.
- Vector from current LFSR:
  - set = l[7]&l[6]
  - clear = l[5]&l[4]
  - din = l[W-1:0]
- Reference model: exp = clear ? 0 : set ? {W{1}} : din. It is captured in the DRIVE cycle.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
  - IDLE: on start=1, go to DRIVE. Load LFSR=SEED, step=0, err_cnt=0, fail_step=FF, pass=0, busy=1.
  - DRIVE (1 cycle): dff_set/dff_clr/dff_din present the vector and exp is registered. Next state is WAIT if LAT>1, else CHECK.
  - WAIT: LAT-1 cycles, counted by an internal counter. dff_set and dff_clr are 0; dff_din holds the last value.
  - CHECK (1 cycle):
    - If dout!=exp, err_cnt+1 (saturating); if fail_step==FF, fail_step=step.
    - Advance LFSR.
    - If step==STEPS-1, go to DONE; else step+1 and go to DRIVE.
  - DONE (1 cycle): done=1, pass=(err_cnt==0 including this update), busy=0 on exit, then IDLE.
- dff_set and dff_clr are 0 outside DRIVE. The bank is not checked outside CHECK.
- Latency: start accepted at edge 0; done high in cycle 1+STEPS*(1+LAT). The default is cycle 17.
- start while busy is ignored and does not restart or extend the run. start in the DONE cycle is also ignored.
- err_cnt, fail_step and pass hold their final values in IDLE until the next accepted start.
- Simultaneous clr=0 and start: reset wins.

Test Plan:
1. Defaults, ideal 1-cycle DFF model, start pulse. Required: first DRIVE presents set=0, clr=0, din=1 (seed A5); second vector comes from LFSR=4A; done at cycle 17; pass=1, err_cnt=0, fail_step=FF.
2. dout tied to 0. Required: err_cnt equals the number of vectors whose exp=1; fail_step is the first such step (0 for seed A5); pass=0.
3. Model inverts dout on step 3 only. Required: err_cnt=1, fail_step=3, pass=0.
4. clr=0 asserted during step 4, released, then new start. Required: outputs zero and fail_step=FF on the next edge; no done pulse; the rerun reproduces the scenario 1 results exactly.
5. Extra start pulses at cycles 5 and 16 of a run. Required: done still at cycle 17; results identical to scenario 1.
6. LAT=2 with a 2-stage DFF model. Required: done at cycle 25, pass=1; dff_set and dff_clr stay low in all WAIT cycles.

Source files
------------

// File: rtl/dff_exerciser.sv
// dff_exerciser: sequences pseudo-random set/clear/data vectors into a bank of
// W D flip-flops, samples the bank LAT cycles later and compares each sample
// against a reference. It reports pass, a mismatch count and the first failing step.
module dff_exerciser #(
  parameter int         W     = 1,
  parameter int         STEPS = 8,
  parameter int         LAT   = 1,
  parameter logic [7:0] SEED  = 8'hA5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] dout,
  output logic         dff_set,
  output logic         dff_clr,
  output logic [W-1:0] dff_din,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   err_cnt,
  output logic [7:0]   fail_step
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] LAST_STEP = 8'(STEPS - 1);
  // The WAIT counter counts down to zero, so it starts at LAT-2.
  localparam logic [1:0] WAIT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

  state_t         state_q, state_d;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [7:0]     step_q, step_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic [W-1:0]   exp_q, exp_d;
  logic           set_q, set_d;
  logic           clr_q, clr_d;
  logic [W-1:0]   din_q, din_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [7:0]     err_q, err_d;
  logic [7:0]     fail_q, fail_d;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  assign dff_set   = set_q;
  assign dff_clr   = clr_q;
  assign dff_din   = din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_step = fail_q;

  // Next-state logic; the vector registers are loaded on entry to DRIVE so
  // they are valid for exactly the DRIVE cycle, and fall back to 0 elsewhere.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    step_d  = step_q;
    wcnt_d  = wcnt_q;
    exp_d   = exp_q;
    set_d   = 1'b0;
    clr_d   = 1'b0;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          lfsr_d  = SEED_EFF;
          step_d  = 8'd0;
          err_d   = 8'd0;
          fail_d  = 8'hFF;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          set_d   = SEED_EFF[7] & SEED_EFF[6];
          clr_d   = SEED_EFF[5] & SEED_EFF[4];
          din_d   = SEED_EFF[W-1:0];
        end
      end
      DRIVE: begin
        // Reference value of the bank: clear dominates set, set dominates data.
        exp_d = clr_q ? '0 : (set_q ? '1 : din_q);
        if (LAT > 1) begin
          state_d = WAIT;
          wcnt_d  = WAIT_INIT;
        end else begin
          state_d = CHECK;
        end
      end
      WAIT: begin
        if (wcnt_q == 2'd0) state_d = CHECK;
        else                wcnt_d  = wcnt_q - 2'd1;
      end
      CHECK: begin
        if (dout != exp_q) begin
          if (err_q != 8'hFF)  err_d  = err_q + 8'd1;
          if (fail_q == 8'hFF) fail_d = step_q;
        end
        lfsr_d = lfsr_next(lfsr_q);
        if (step_q == LAST_STEP) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end else begin
          state_d = DRIVE;
          step_d  = step_q + 8'd1;
          set_d   = lfsr_d[7] & lfsr_d[6];
          clr_d   = lfsr_d[5] & lfsr_d[4];
          din_d   = lfsr_d[W-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      step_q  <= 8'd0;
      wcnt_q  <= 2'd0;
      exp_q   <= '0;
      set_q   <= 1'b0;
      clr_q   <= 1'b0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 8'd0;
      fail_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      step_q  <= step_d;
      wcnt_q  <= wcnt_d;
      exp_q   <= exp_d;
      set_q   <= set_d;
      clr_q   <= clr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

endmodule

// File: tb/tb_dff_exerciser.sv
// Bench for dff_exerciser: a LAT=1 and a LAT=2 instance, each driving a
// behavioural flip-flop bank; expected vectors and run results are queued when
// a run is started and popped as the DUT presents them.
module tb_dff_exerciser;
  localparam int W     = 1;
  localparam int STEPS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clr, start1, start2;
  logic [W-1:0] dout1, dout2;
  logic         set1, cl1, busy1, done1, pass1;
  logic         set2, cl2, busy2, done2, pass2;
  logic [W-1:0] din1, din2;
  logic [7:0]   err1, fst1, err2, fst2;

  dff_exerciser #(.W(W), .STEPS(STEPS), .LAT(1), .SEED(8'hA5)) dut1 (
    .clk(clk), .clr(clr), .start(start1), .dout(dout1),
    .dff_set(set1), .dff_clr(cl1), .dff_din(din1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_step(fst1));

  dff_exerciser #(.W(W), .STEPS(STEPS), .LAT(2), .SEED(8'hA5)) dut2 (
    .clk(clk), .clr(clr), .start(start2), .dout(dout2),
    .dff_set(set2), .dff_clr(cl2), .dff_din(din2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_step(fst2));

  // Behavioural banks: one stage for dut1, two stages for dut2.
  int           mode = 0;
  logic         inv  = 1'b0;
  logic [W-1:0] b1, b2a, b2b;
  always @(posedge clk) begin
    b1  <= cl1 ? '0 : (set1 ? '1 : din1);
    b2a <= cl2 ? '0 : (set2 ? '1 : din2);
    b2b <= b2a;
  end
  assign dout1 = (mode == 1) ? '0 : (inv ? ~b1  : b1);
  assign dout2 = (mode == 1) ? '0 : (inv ? ~b2b : b2b);

  logic         sel = 1'b0;
  logic         o_set, o_clr, o_busy, o_done, o_pass;
  logic [W-1:0] o_din;
  logic [7:0]   o_err, o_fst;
  assign o_set  = sel ? set2  : set1;
  assign o_clr  = sel ? cl2   : cl1;
  assign o_din  = sel ? din2  : din1;
  assign o_busy = sel ? busy2 : busy1;
  assign o_done = sel ? done2 : done1;
  assign o_pass = sel ? pass2 : pass1;
  assign o_err  = sel ? err2  : err1;
  assign o_fst  = sel ? fst2  : fst1;

  typedef struct packed { logic s; logic c; logic [W-1:0] d; } vec_t;
  typedef struct packed { logic p; logic [7:0] e; logic [7:0] f; } res_t;
  vec_t vq[$];
  res_t rq[$];
  int checks = 0;
  int fails  = 0;

  function automatic logic [7:0] nxt(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  // Reference: vectors from the seed, bank response per mode, final results.
  task automatic push_expected(input int md);
    logic [7:0]   l;
    vec_t         v;
    res_t         r;
    logic [W-1:0] e, d;
    int           err, fs;
    l = 8'hA5; err = 0; fs = 255;
    for (int s = 0; s < STEPS; s++) begin
      v.s = l[7] & l[6];
      v.c = l[5] & l[4];
      v.d = l[W-1:0];
      e = v.c ? '0 : (v.s ? '1 : v.d);
      d = (md == 1) ? '0 : ((md == 2 && s == 3) ? ~e : e);
      if (d != e) begin
        if (err < 255) err++;
        if (fs == 255) fs = s;
      end
      vq.push_back(v);
      l = nxt(l);
    end
    r.p = (err == 0); r.e = 8'(err); r.f = 8'(fs);
    rq.push_back(r);
  endtask

  // One full run; x1/x2 are cycles in which an extra start pulse is driven.
  task automatic run(input string name, input bit s2, input int md, input int x1, input int x2);
    int   per, dcyc;
    vec_t v;
    res_t r;
    per  = s2 ? 3 : 2;
    dcyc = 1 + STEPS * per;
    sel = s2; mode = md; inv = 1'b0;
    push_expected(md);
    @(negedge clk);
    if (s2) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= dcyc + 2; k++) begin
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0; inv = 1'b0;
      if (k < dcyc && (k - 1) % per == 0) begin
        checks++;
        if (vq.size() == 0) begin
          fails++; $display("FAIL %s vec_underflow k=%0d", name, k);
        end else begin
          v = vq.pop_front();
          if ({o_set, o_clr, o_din} !== v) begin
            fails++;
            $display("FAIL %s vector k=%0d got=%b want=%b", name, k, {o_set, o_clr, o_din}, v);
          end
        end
      end else begin
        checks++;
        if ({o_set, o_clr} !== 2'b00) begin
          fails++; $display("FAIL %s setclr_low k=%0d got=%b want=00", name, k, {o_set, o_clr});
        end
      end
      checks++;
      if (o_done !== (k == dcyc)) begin
        fails++; $display("FAIL %s done k=%0d got=%b want=%b", name, k, o_done, (k == dcyc));
      end
      if (k == 1 || k == dcyc || k == dcyc + 1) begin
        checks++;
        if (o_busy !== (k <= dcyc)) begin
          fails++; $display("FAIL %s busy k=%0d got=%b want=%b", name, k, o_busy, (k <= dcyc));
        end
      end
      if (k == x1 || k == x2) begin
        if (s2) start2 = 1'b1; else start1 = 1'b1;
      end
      if (md == 2 && k == 4 * per) inv = 1'b1;
    end
    r = rq.pop_front();
    checks++;
    if ({o_pass, o_err, o_fst} !== r) begin
      fails++;
      $display("FAIL %s result got pass=%b err=%0d fstep=%0h want pass=%b err=%0d fstep=%0h",
               name, o_pass, o_err, o_fst, r.p, r.e, r.f);
    end
    checks++;
    if (vq.size() != 0) begin
      fails++; $display("FAIL %s vec_leftover got=%0d want=0", name, vq.size());
      vq.delete();
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; start1 = 1'b1; start2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy1, done1, pass1, set1, cl1, din1, err1, fst1} !== {5'b0, {W{1'b0}}, 8'h00, 8'hFF}) begin
      fails++; $display("FAIL reset_dut1 busy=%b done=%b pass=%b err=%0d fstep=%0h", busy1, done1, pass1, err1, fst1);
    end
    checks++;
    if ({busy2, done2, pass2, set2, cl2, din2, err2, fst2} !== {5'b0, {W{1'b0}}, 8'h00, 8'hFF}) begin
      fails++; $display("FAIL reset_dut2 busy=%b done=%b pass=%b err=%0d fstep=%0h", busy2, done2, pass2, err2, fst2);
    end
    clr = 1'b1; start1 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      fails++; $display("FAIL reset_wins busy1=%b busy2=%b want=0", busy1, busy2);
    end
  endtask

  task automatic test_midrun_reset();
    sel = 1'b0; mode = 0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (k == 9) clr = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({busy1, done1, pass1, set1, cl1, din1, err1, fst1} !== {5'b0, {W{1'b0}}, 8'h00, 8'hFF}) begin
      fails++; $display("FAIL midrun_reset busy=%b done=%b set=%b clr=%b err=%0d fstep=%0h",
                        busy1, done1, set1, cl1, err1, fst1);
    end
    clr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        fails++; $display("FAIL abandoned_run k=%0d done=%b busy=%b want=0", k, done1, busy1);
      end
    end
  endtask

  initial begin
    clr = 1'b0; start1 = 1'b0; start2 = 1'b0;
    test_reset();
    run("ideal",        1'b0, 0,  0,  0);
    run("dout_zero",    1'b0, 1,  0,  0);
    run("invert_step3", 1'b0, 2,  0,  0);
    test_midrun_reset();
    run("rerun",        1'b0, 0,  0,  0);
    run("extra_start",  1'b0, 0,  5, 16);
    run("done_start",   1'b0, 0, 17,  0);
    run("lat2",         1'b1, 0,  0,  0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
